// File: rtl/activation_skew_feeder.sv
// Buffers X_SCALED activation rows in per-row FIFOs and streams them out with row r
// delayed by r cycles, forming the diagonal wavefront the systolic array consumes.
module activation_skew_feeder #(
    parameter int MUL_DATAWIDTH = 8,
    parameter int M             = 2,
    parameter int BETA          = 4,
    parameter int X_SCALED      = 4,
    parameter int FIFO_DEPTH    = 8,
    parameter int VEC_W         = MUL_DATAWIDTH * M * BETA
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [X_SCALED-1:0][VEC_W-1:0]   act_fifo_data,
    input  logic [X_SCALED-1:0]              act_fifo_valid,
    input  logic                             stream_start,
    input  logic [7:0]                       stream_len,
    input  logic                             compute_stall,
    output logic [X_SCALED-1:0][VEC_W-1:0]   act_in,
    output logic [X_SCALED-1:0]              act_in_valid,
    output logic                             stream_done,
    output logic                             busy,
    output logic [X_SCALED-1:0]              fifo_full,
    output logic                             overflow_err,
    output logic                             len_err
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int DW = (X_SCALED > 1) ? $clog2(X_SCALED) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_STREAM, S_DRAIN} state_e;

    state_e              state_q, state_d;
    logic [7:0]          rem_q, rem_d;
    logic [DW-1:0]       drain_q, drain_d;
    logic                done_q, done_d;
    logic                len_err_q, len_err_d;
    logic                overflow_err_q;

    logic [VEC_W-1:0]    mem_q    [X_SCALED][FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr_q [X_SCALED];
    logic [PW-1:0]       rd_ptr_q [X_SCALED];
    logic [CW-1:0]       count_q  [X_SCALED];

    logic                pop;
    logic [X_SCALED-1:0] push;
    logic                ovf_hit;

    assign pop = (state_q == S_STREAM) && !compute_stall;

    // A full row still accepts a write in a cycle that also pops it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        push    = '0;
        ovf_hit = 1'b0;
        for (int r = 0; r < X_SCALED; r++) begin
            if (act_fifo_valid[r]) begin
                if (count_q[r] != CW'(FIFO_DEPTH) || pop) push[r] = 1'b1;
                else                                      ovf_hit = 1'b1;
            end
        end
    end

    always_comb begin
        fifo_full = '0;
        for (int r = 0; r < X_SCALED; r++) fifo_full[r] = (count_q[r] == CW'(FIFO_DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < X_SCALED; r++) begin
                wr_ptr_q[r] <= '0;
                rd_ptr_q[r] <= '0;
                count_q[r]  <= '0;
            end
            overflow_err_q <= 1'b0;
        end else begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            for (int r = 0; r < X_SCALED; r++) begin
                if (push[r]) wr_ptr_q[r] <= wr_ptr_q[r] + 1'b1;
                if (pop)     rd_ptr_q[r] <= rd_ptr_q[r] + 1'b1;
                case ({push[r], pop})
                    2'b10:   count_q[r] <= count_q[r] + 1'b1;
                    2'b01:   count_q[r] <= count_q[r] - 1'b1;
                    default: ;
                endcase
            end
            if (ovf_hit) overflow_err_q <= 1'b1;
        end
    end

    // NOTE: FIFO storage is deliberately not reset; pointers and counts define what is valid.
    always_ff @(posedge clk) begin
        for (int r = 0; r < X_SCALED; r++) begin
            if (push[r]) mem_q[r][wr_ptr_q[r]] <= act_fifo_data[r];
        end
    end

    always_comb begin
        logic all_ready;
        state_d   = state_q;
        rem_d     = rem_q;
        drain_d   = drain_q;
        done_d    = 1'b0;
        len_err_d = len_err_q;
        all_ready = 1'b1;
        for (int r = 0; r < X_SCALED; r++) begin
            if (int'(count_q[r]) < int'(rem_q)) all_ready = 1'b0;
        end
        unique case (state_q)
            S_IDLE: begin
                if (stream_start) begin
                    if (stream_len == 8'd0) begin
                        done_d = 1'b1;
                    end else if (int'(stream_len) > FIFO_DEPTH) begin
                        done_d    = 1'b1;
                        len_err_d = 1'b1;
                    end else begin
                        rem_d   = stream_len;
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (all_ready) state_d = S_STREAM;
            end
            S_STREAM: begin
                if (!compute_stall) begin
                    rem_d = rem_q - 8'd1;
                    if (rem_q == 8'd1) begin
                        state_d = S_DRAIN;
                        drain_d = DW'(X_SCALED - 1);
                        done_d  = (X_SCALED == 1);
                    end
                end
            end
            S_DRAIN: begin
                // drain_q counts the cycles until the last row's final vector is presented.
                if (!compute_stall) begin
                    if (drain_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        drain_d = drain_q - 1'b1;
                        done_d  = (drain_q == DW'(1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            rem_q     <= '0;
            drain_q   <= '0;
            done_q    <= 1'b0;
            len_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            drain_q   <= drain_d;
            done_q    <= done_d;
            len_err_q <= len_err_d;
        end
    end

    // Row r: one output register plus r skew stages; empty slots carry zero data.
    for (genvar r = 0; r < X_SCALED; r++) begin : g_row
        logic [VEC_W-1:0] sd_q [r+1];
        logic [r:0]       sv_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int s = 0; s <= r; s++) sd_q[s] <= '0;
                sv_q <= '0;
            end else if (!compute_stall) begin
                sd_q[0] <= pop ? mem_q[r][rd_ptr_q[r]] : '0;
                sv_q[0] <= pop;
                for (int s = 1; s <= r; s++) begin
                    sd_q[s] <= sd_q[s-1];
                    sv_q[s] <= sv_q[s-1];
                end
            end
        end

        assign act_in[r]       = sd_q[r];
        assign act_in_valid[r] = sv_q[r];
    end

    assign stream_done  = done_q;
    assign busy         = (state_q != S_IDLE);
    assign overflow_err = overflow_err_q;
    assign len_err      = len_err_q;

endmodule

// File: tb/tb_activation_skew_feeder.sv
// Bench for activation_skew_feeder: directed scenarios plus randomized traffic, all
// checked every cycle against a queue-based reference of the feeder's behaviour.
module tb_activation_skew_feeder;

    localparam int X  = 4;
    localparam int D  = 8;
    localparam int VW = 64;

    typedef logic [VW-1:0] vec_t;
    typedef enum {P_IDLE, P_WAIT, P_RUN} phase_t;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [X-1:0][VW-1:0] act_fifo_data;
    logic [X-1:0]         act_fifo_valid;
    logic                 stream_start;
    logic [7:0]           stream_len;
    logic                 compute_stall;
    logic [X-1:0][VW-1:0] act_in;
    logic [X-1:0]         act_in_valid;
    logic                 stream_done;
    logic                 busy;
    logic [X-1:0]         fifo_full;
    logic                 overflow_err;
    logic                 len_err;

    activation_skew_feeder dut (
        .clk            (clk),
        .rst            (rst),
        .act_fifo_data  (act_fifo_data),
        .act_fifo_valid (act_fifo_valid),
        .stream_start   (stream_start),
        .stream_len     (stream_len),
        .compute_stall  (compute_stall),
        .act_in         (act_in),
        .act_in_valid   (act_in_valid),
        .stream_done    (stream_done),
        .busy           (busy),
        .fifo_full      (fifo_full),
        .overflow_err   (overflow_err),
        .len_err        (len_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Reference: row queues, the vectors popped in the current stream, and the
    // number j of unstalled cycles since the stream entered its output phase.
    vec_t   q      [X][$];
    vec_t   popped [X][$];
    phase_t phase;
    int     j, lm;
    bit     done_m, ovf_m, lerr_m;

    task automatic model_reset();
        for (int r = 0; r < X; r++) begin
            q[r].delete();
            popped[r].delete();
        end
        phase  = P_IDLE;
        j      = 0;
        lm     = 0;
        done_m = 1'b0;
        ovf_m  = 1'b0;
        lerr_m = 1'b0;
    endtask

    task automatic compare_outputs();
        logic [X-1:0] exp_v;
        logic [X-1:0] exp_f;
        exp_v = '0;
        exp_f = '0;
        for (int r = 0; r < X; r++) begin
            vec_t exp_d;
            int   k;
            exp_d = '0;
            k     = j - 1 - r;
            if (phase == P_RUN && k >= 0 && k < lm) begin
                exp_v[r] = 1'b1;
                exp_d    = popped[r][k];
            end
            check($sformatf("act_in[%0d]", r), act_in[r], exp_d);
            exp_f[r] = (q[r].size() == D);
        end
        check("act_in_valid", act_in_valid, exp_v);
        check("stream_done", stream_done, done_m);
        check("busy", busy, phase != P_IDLE);
        check("fifo_full", fifo_full, exp_f);
        check("overflow_err", overflow_err, ovf_m);
        check("len_err", len_err, lerr_m);
    endtask

    task automatic model_update();
        bit pop;
        bit done_n;
        bit all_ok;
        pop    = 1'b0;
        done_n = 1'b0;
        case (phase)
            P_IDLE: begin
                if (stream_start) begin
                    if (stream_len == 0) begin
                        done_n = 1'b1;
                    end else if (stream_len > D) begin
                        done_n = 1'b1;
                        lerr_m = 1'b1;
                    end else begin
                        lm    = stream_len;
                        phase = P_WAIT;
                    end
                end
            end
            P_WAIT: begin
                all_ok = 1'b1;
                for (int r = 0; r < X; r++) if (q[r].size() < lm) all_ok = 1'b0;
                if (all_ok) begin
                    phase = P_RUN;
                    j     = 0;
                    for (int r = 0; r < X; r++) popped[r].delete();
                end
            end
            default: begin
                if (!compute_stall) begin
                    pop = (j < lm);
                    j++;
                    if (j == lm + X - 1) done_n = 1'b1;
                    if (j == lm + X)     phase  = P_IDLE;
                end
            end
        endcase
        for (int r = 0; r < X; r++) begin
            bit acc;
            acc = 1'b0;
            if (act_fifo_valid[r]) begin
                if (q[r].size() < D || pop) acc   = 1'b1;
                else                        ovf_m = 1'b1;
            end
            if (pop) popped[r].push_back(q[r].pop_front());
            if (acc) q[r].push_back(act_fifo_data[r]);
        end
        done_m = done_n;
    endtask

    // One clock cycle: inputs are already driven; check at negedge, update model at posedge.
    task automatic step();
        @(negedge clk);
        compare_outputs();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic idle_inputs();
        act_fifo_valid = '0;
        act_fifo_data  = '0;
        stream_start   = 1'b0;
        stream_len     = 8'd0;
        compute_stall  = 1'b0;
    endtask

    task automatic write_cycle(input logic [X-1:0] mask, input int k);
        idle_inputs();
        act_fifo_valid = mask;
        for (int r = 0; r < X; r++) act_fifo_data[r] = vec_t'(16 * r + k);
        step();
    endtask

    task automatic start_cycle(input int len);
        idle_inputs();
        stream_start = 1'b1;
        stream_len   = 8'(len);
        step();
    endtask

    task automatic run_until_idle(input int budget);
        idle_inputs();
        for (int c = 0; c < budget && phase != P_IDLE; c++) step();
        if (phase != P_IDLE) check("stream_timeout", busy, 1'b0);
        step();
        step();
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        compare_outputs();
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            compare_outputs();
        end
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        model_reset();
        #2;
        compare_outputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        step();

        // Directed fill of 16*r+k, then a 4-deep stream.
        for (int k = 0; k < 4; k++) write_cycle('1, k);
        start_cycle(4);
        run_until_idle(30);

        // Row 3 empty holds the stream in its wait phase until it catches up.
        for (int k = 0; k < 3; k++) write_cycle(4'b0111, k);
        start_cycle(3);
        idle_inputs();
        for (int c = 0; c < 5; c++) step();
        for (int k = 0; k < 3; k++) write_cycle(4'b1000, k + 8);
        run_until_idle(30);

        // Two stalled cycles in the middle of a 4-deep stream.
        for (int k = 0; k < 4; k++) write_cycle('1, k + 4);
        start_cycle(4);
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            compute_stall = (i == 4 || i == 5);
            step();
        end
        run_until_idle(30);

        // Nine writes into row 1: the ninth is dropped and flags overflow.
        for (int k = 0; k < 9; k++) write_cycle((k < 8) ? 4'b1111 : 4'b0010, k);
        start_cycle(8);
        run_until_idle(40);

        // Degenerate lengths.
        start_cycle(0);
        idle_inputs();
        step();
        step();
        start_cycle(9);
        idle_inputs();
        step();
        step();

        // Reset in the drain phase, then a fresh fill-and-stream.
        for (int k = 0; k < 4; k++) write_cycle('1, k);
        start_cycle(4);
        idle_inputs();
        for (int c = 0; c < 20 && !(phase == P_RUN && j == lm + 1); c++) step();
        apply_reset();
        step();
        for (int k = 0; k < 4; k++) write_cycle('1, k + 1);
        start_cycle(4);
        run_until_idle(30);

        // Randomized traffic: writes, stalls and stray starts at any time.
        for (int t = 0; t < 40; t++) begin
            int pre;
            pre = $urandom_range(0, 4);
            for (int c = 0; c < pre; c++) begin
                idle_inputs();
                act_fifo_valid = X'($urandom);
                for (int r = 0; r < X; r++) act_fifo_data[r] = {$urandom, $urandom};
                step();
            end
            start_cycle($urandom_range(0, 9));
            for (int c = 0; c < 200 && phase != P_IDLE; c++) begin
                idle_inputs();
                act_fifo_valid = X'($urandom);
                for (int r = 0; r < X; r++) act_fifo_data[r] = {$urandom, $urandom};
                compute_stall = ($urandom_range(0, 4) == 0);
                stream_start  = ($urandom_range(0, 7) == 0);
                stream_len    = 8'($urandom_range(0, 9));
                step();
            end
            if (phase != P_IDLE) check("stream_timeout", busy, 1'b0);
        end
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
